pokey_clk_div: RTL and testbench
================================

# pokey_clk_div

Multi-channel programmable clock-enable generator for the POKEY audio path, succeeding the fixed divide-by-two stage. Each channel divides `inClk` by a runtime-loaded ratio and produces both a single-cycle `tick` enable and a 50%-duty square `outClk`. Sits between the system clock and the POKEY audio channel counters and base-clock selectors. All outputs are registered, and no derived clock is used as a clock elsewhere in the design.

## Interface
- `NUM_CH`, default 4: number of channels. Must be even and ≥2.
- `DIV_W`, default 8: divisor width per channel.

- `inClk`  in  1: system clock. Everything is on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `en`  in  1: global run enable.
- `load`  in  NUM_CH: per-channel load strobe.
- `div`  in  NUM_CH*DIV_W: divisor values. Channel i uses `div[i*DIV_W +: DIV_W]`.
- `join`  in  NUM_CH/2: cascade select for channel pair k, which is channels 2k and 2k+1. Only has effect with `CLKDIV_CASCADE_EN`.
- `tick`  out  NUM_CH: registered one-cycle enable pulse per channel.
- `outClk`  out  NUM_CH: registered square wave per channel. It toggles on every tick.

## Operation
- Per-channel state:
  - `div_r[i]` (DIV_W bits): the latched divisor.
  - `cnt[i]` (DIV_W bits): a down-counter.
  - the `tick[i]` and `outClk[i]` registers.
- Reset values: `div_r=0`, `cnt=0`, `tick=0`, `outClk=0`. These apply to all channels.
- Channel i is stepping (`step_i`) when `en=1`. For a cascaded high channel, the extra condition below also applies.
- Terminal event: `term_i = step_i && cnt[i]==0`.
- Each rising edge applies the following, in priority order:
  1. `load[i]=1`: `div_r[i]` and `cnt[i]` both take the `div` slice. `tick[i]` is set to 0. `outClk[i]` holds. Load works regardless of `en`.
  2. `term_i`: `cnt[i]` is set to `div_r[i]`, `tick[i]` is set to 1, and `outClk[i]` toggles.
  3. `step_i` with cnt≠0: `cnt[i]` decrements and `tick[i]` is set to 0.
  4. Otherwise (`en=0`): `cnt` and `outClk` hold, and `tick[i]` is set to 0.
- Divide ratio is D+1 for divisor D.
  - `tick` period is D+1 cycles.
  - `outClk` period is 2(D+1) cycles.
  - D=0 gives a `tick` every cycle and `outClk = inClk/2`, matching the legacy half-rate clock.
- Arithmetic is unsigned. The counter never underflows, because 0 always reloads.
- Channels are independent unless cascaded.

## Timing
- Latency from load to tick: with `load` at edge E and `en` held high, the first `tick` is high after edge E+D+1. Subsequent ticks follow every D+1 edges.
- Simultaneous `load` and terminal event: load wins, the terminal tick is suppressed, and `outClk` does not toggle.
- Deasserting `en` freezes phase exactly. Reasserting it resumes the count with no lost or extra cycle.
- `reset` asserted mid-count clears all state immediately (asynchronously). After release, `div_r=0`, so the channel ticks every enabled cycle until it is reloaded.
- Changing `div` without `load` has no effect.

## Configuration
- Macro: `CLKDIV_CASCADE_EN`.
- Defined:
  - When `join[k]=1`, channel 2k+1 steps only when `term_{2k}` is true, giving a joined divider of ratio (D_lo+1)·(D_hi+1).
  - `tick[2k+1]` and `outClk[2k+1]` then give the joined output.
  - Channel 2k is unaffected.
  - `load` of either channel of a pair affects only that channel's counter.
- Undefined:
  - The `join` port is still present but ignored (treated as 0).
  - All channels are independent.

## Test plan
- Reset then `en=1`, no loads: every `tick` is 1 each cycle from the 2nd edge after release, and every `outClk` toggles each cycle (half rate).
- Load ch0 with D=4 at edge E, `en=1`: `tick[0]` is high after edges E+5, E+10, E+15. `outClk[0]` has period 10 cycles at 50% duty.
- Ch1 D=2 running, then drop `en` for 7 cycles: no ticks during the gap, and the tick spacing across the gap is exactly 3 enabled cycles.
- Pulse `load[2]` with D=6 on the same edge ch2's terminal event would fire: no tick on that edge, and the next tick comes 7 cycles later.
- Assert `reset` mid-count on ch3 (D=9, cnt=5): all outputs are 0 immediately. After release, ch3 ticks every cycle.
- With `CLKDIV_CASCADE_EN`, `join[0]=1`, ch0 D=3, ch1 D=4: `tick[1]` period is 20 cycles and `outClk[1]` period is 40. Without the macro, the same stimulus gives a `tick[1]` period of 5.

Source files
------------

// File: rtl/pokey_clk_div.sv
// Multi-channel programmable clock-enable generator: divide-by-(D+1) tick plus 50% square out.
// Optional pair cascading is compiled in with `define CLKDIV_CASCADE_EN.
module pokey_clk_div #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = 8
) (
  input  logic                    i_inClk,
  input  logic                    i_reset,
  input  logic                    i_en,
  input  logic [NUM_CH-1:0]       i_load,
  input  logic [NUM_CH*DIV_W-1:0] i_div,
  input  logic [NUM_CH/2-1:0]     i_join,
  output logic [NUM_CH-1:0]       o_tick,
  output logic [NUM_CH-1:0]       o_outClk
);

  logic [NUM_CH/2-1:0] w_join;
  logic [NUM_CH-1:0]   w_cnt_zero;
  logic [NUM_CH-1:0]   w_step;
  logic [NUM_CH-1:0]   w_term;

`ifdef CLKDIV_CASCADE_EN
  assign w_join = i_join;
`else
  logic w_unused_join;
  assign w_join        = '0;
  assign w_unused_join = ^i_join;
`endif

  // The high channel of a joined pair advances only on the low channel's terminal event.
  // Its step is built from the low counter's zero flag directly to keep the logic acyclic.
  for (genvar k = 0; k < NUM_CH / 2; k++) begin : g_pair
    assign w_step[2*k]   = i_en;
    assign w_step[2*k+1] = i_en & (~w_join[k] | w_cnt_zero[2*k]);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             r_tick;
    logic             r_out;
    logic [DIV_W-1:0] w_div_in;

    assign w_div_in      = i_div[i*DIV_W +: DIV_W];
    assign w_cnt_zero[i] = (r_cnt == '0);
    assign w_term[i]     = w_step[i] & w_cnt_zero[i];

    // Load beats the terminal event, so a colliding reload suppresses the tick and toggle.
    always_ff @(posedge i_inClk or posedge i_reset) begin
      if (i_reset) begin
        r_div  <= '0;
        r_cnt  <= '0;
        r_tick <= 1'b0;
        r_out  <= 1'b0;
      end else if (i_load[i]) begin
        r_div  <= w_div_in;
        r_cnt  <= w_div_in;
        r_tick <= 1'b0;
      end else if (w_term[i]) begin
        r_cnt  <= r_div;
        r_tick <= 1'b1;
        r_out  <= ~r_out;
      end else if (w_step[i]) begin
        r_cnt  <= r_cnt - 1'b1;
        r_tick <= 1'b0;
      end else begin
        r_tick <= 1'b0;
      end
    end

    assign o_tick[i]   = r_tick;
    assign o_outClk[i] = r_out;
  end

endmodule

// File: tb/tb_pokey_clk_div.sv
// Directed self-checking bench for pokey_clk_div; cascade expectations follow CLKDIV_CASCADE_EN.
module tb_pokey_clk_div;

  logic        clk;
  logic        reset;
  logic        en;
  logic [3:0]  load;
  logic [31:0] div;
  logic [1:0]  join_sel;
  logic [3:0]  tick;
  logic [3:0]  out_clk;

  int n_pass;
  int n_total;

  pokey_clk_div #(
    .NUM_CH(4),
    .DIV_W (8)
  ) dut (
    .i_inClk (clk),
    .i_reset (reset),
    .i_en    (en),
    .i_load  (load),
    .i_div   (div),
    .i_join  (join_sel),
    .o_tick  (tick),
    .o_outClk(out_clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    logic exp_b;
    n_pass   = 0;
    n_total  = 0;
    reset    = 1'b1;
    en       = 1'b0;
    load     = '0;
    div      = '0;
    join_sel = '0;

    // Reset state and idle cycle.
    repeat (2) step();
    chk("rst_tick", {28'd0, tick}, 32'h0);
    chk("rst_out", {28'd0, out_clk}, 32'h0);
    reset = 1'b0;
    step();
    chk("idle_tick", {28'd0, tick}, 32'h0);

    // Divisor 0 after reset: tick every cycle, half-rate outClk.
    en = 1'b1;
    step();
    chk("half_tick1", {28'd0, tick}, 32'hF);
    chk("half_out1", {28'd0, out_clk}, 32'hF);
    step();
    chk("half_tick2", {28'd0, tick}, 32'hF);
    chk("half_out2", {28'd0, out_clk}, 32'h0);
    step();
    chk("half_tick3", {28'd0, tick}, 32'hF);
    chk("half_out3", {28'd0, out_clk}, 32'hF);

    // ch0 D=4: tick every 5, outClk period 10.
    div[7:0] = 8'd4;
    load     = 4'b0001;
    step();
    chk("ld0_tick", {28'd0, tick}, 32'hE);
    chk("ld0_out", {28'd0, out_clk}, 32'h1);
    load = '0;
    for (int n = 1; n <= 15; n++) begin
      step();
      chk($sformatf("d4_tick_%0d", n), {31'd0, tick[0]}, {31'd0, (n % 5) == 0});
      exp_b = ((n / 5) % 2) == 0;
      chk($sformatf("d4_out_%0d", n), {31'd0, out_clk[0]}, {31'd0, exp_b});
    end

    // ch1 D=2 with a 7-cycle en gap: phase must freeze exactly.
    div[15:8] = 8'd2;
    load      = 4'b0010;
    step();
    chk("ld1_tick", {31'd0, tick[1]}, 32'h0);
    load = '0;
    for (int n = 1; n <= 3; n++) begin
      step();
      chk($sformatf("d2_tick_%0d", n), {31'd0, tick[1]}, {31'd0, n == 3});
    end
    step();
    chk("pregap_tick", {31'd0, tick[1]}, 32'h0);
    en = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      step();
      chk($sformatf("gap_tick_%0d", n), {28'd0, tick}, 32'h0);
    end
    en        = 1'b1;
    div[15:8] = 8'd7;  // no load: must be ignored
    step();
    chk("resume_tick1", {31'd0, tick[1]}, 32'h0);
    step();
    chk("resume_tick2", {31'd0, tick[1]}, 32'h1);
    for (int n = 1; n <= 3; n++) begin
      step();
      chk($sformatf("nold_tick_%0d", n), {31'd0, tick[1]}, {31'd0, n == 3});
    end

    // ch3 D=9 counted down to 5, then asynchronous reset mid-count.
    div[31:24] = 8'd9;
    load       = 4'b1000;
    step();
    load = '0;
    repeat (4) step();
    chk("pre_rst_tick2", {31'd0, tick[2]}, 32'h1);
    reset = 1'b1;
    #1;
    chk("async_rst_tick", {28'd0, tick}, 32'h0);
    chk("async_rst_out", {28'd0, out_clk}, 32'h0);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_tick1", {28'd0, tick}, 32'hF);
    chk("post_rst_out1", {28'd0, out_clk}, 32'hF);
    step();
    chk("post_rst_tick2", {28'd0, tick}, 32'hF);
    chk("post_rst_out2", {28'd0, out_clk}, 32'h0);

    // ch2: load colliding with its terminal event.
    div[23:16] = 8'd1;
    load       = 4'b0100;
    step();
    chk("ld2_tick", {28'd0, tick}, 32'hB);
    chk("ld2_out", {28'd0, out_clk}, 32'hB);
    load = '0;
    step();
    chk("d1_tick_1", {31'd0, tick[2]}, 32'h0);
    step();
    chk("d1_tick_2", {31'd0, tick[2]}, 32'h1);
    chk("d1_out_2", {31'd0, out_clk[2]}, 32'h1);
    step();
    chk("d1_tick_3", {31'd0, tick[2]}, 32'h0);
    div[23:16] = 8'd6;
    load       = 4'b0100;
    step();
    chk("coll_tick", {31'd0, tick[2]}, 32'h0);
    chk("coll_out", {31'd0, out_clk[2]}, 32'h1);
    load = '0;
    for (int n = 5; n <= 11; n++) begin
      step();
      chk($sformatf("d6_tick_%0d", n), {31'd0, tick[2]}, {31'd0, n == 11});
    end
    chk("d6_out", {31'd0, out_clk[2]}, 32'h0);

    // Pair 0 joined: ch0 D=3, ch1 D=4.
    reset = 1'b1;
    step();
    reset     = 1'b0;
    join_sel  = 2'b01;
    div[7:0]  = 8'd3;
    div[15:8] = 8'd4;
    load      = 4'b0011;
    step();
    chk("cas_ld_tick", {30'd0, tick[1:0]}, 32'h0);
    chk("cas_ld_out", {30'd0, out_clk[1:0]}, 32'h0);
    load = '0;
    for (int n = 1; n <= 40; n++) begin
      step();
      chk($sformatf("cas_tick0_%0d", n), {31'd0, tick[0]}, {31'd0, (n % 4) == 0});
`ifdef CLKDIV_CASCADE_EN
      exp_b = (n % 20) == 0;
      chk($sformatf("cas_tick1_%0d", n), {31'd0, tick[1]}, {31'd0, exp_b});
      exp_b = ((n / 20) % 2) == 1;
      chk($sformatf("cas_out1_%0d", n), {31'd0, out_clk[1]}, {31'd0, exp_b});
`else
      exp_b = (n % 5) == 0;
      chk($sformatf("cas_tick1_%0d", n), {31'd0, tick[1]}, {31'd0, exp_b});
      exp_b = ((n / 5) % 2) == 1;
      chk($sformatf("cas_out1_%0d", n), {31'd0, out_clk[1]}, {31'd0, exp_b});
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
